// File: rtl/wb_uart_tx.sv
// Wishbone-attached 8N1 UART transmitter with a transmit FIFO.
// Registers: 0 TXDATA (wo), 1 STATUS, 2 DIVISOR (rw), 3 reserved.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wb_adr_i[1:0]               word register select
//   wb_dat_i/wb_dat_o[31:0]     write / read data
//   wb_we_i, wb_sel_i[3:0]      write enable, byte lanes
//   wb_stb_i, wb_ack_o          strobe, registered acknowledge
//   tx_o                        serial output, idle high
module wb_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] RESET_DIV  = 16'd433
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        tx_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   divisor;

    logic [1:0]    state;
    logic [15:0]   baud_cnt;
    logic [15:0]   cur_div;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          bus_cyc;
    logic          bus_wr;
    logic          bus_rd;
    logic          empty;
    logic          full;
    logic          busy;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          pop;
    logic          ovf_clr;
    logic          bit_end;
    logic [2:0]    nxt_idx;
    logic [7:0]    count8;
    logic [31:0]   status;
    logic [31:0]   rd_data;

    // A new bus access starts only when ack is low, so a held
    // strobe is acknowledged every other cycle.
    assign bus_cyc  = wb_stb_i & ~wb_ack_o;
    assign bus_wr   = bus_cyc & wb_we_i;
    assign bus_rd   = bus_cyc & ~wb_we_i;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign busy     = (state != S_IDLE);

    assign push_req = bus_wr & (wb_adr_i == 2'd0) & wb_sel_i[0];
    assign push     = push_req & ~full;
    assign drop     = push_req & full;
    assign ovf_clr  = bus_wr & (wb_adr_i == 2'd1)
                    & wb_sel_i[0] & wb_dat_i[3];

    assign bit_end  = (baud_cnt == cur_div);
    assign nxt_idx  = bit_idx + 3'd1;

    // The FSM pops whenever it is about to start a frame.
    assign pop = ~empty & ((state == S_IDLE) |
                           ((state == S_STOP) & bit_end));

    assign count8 = 8'(count);
    assign status = {16'd0, count8, 4'd0,
                     overflow, busy, empty, full};

    always_comb begin
        rd_data = '0;
        unique case (wb_adr_i)
            2'd1:    rd_data = status;
            2'd2:    rd_data = {16'd0, divisor};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_cyc;
            wb_dat_o <= bus_rd ? rd_data : '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            divisor <= RESET_DIV;
        end else if (bus_wr && wb_adr_i == 2'd2) begin
            if (wb_sel_i[0]) divisor[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) divisor[15:8] <= wb_dat_i[15:8];
        end
    end

    // A drop wins over a same-cycle clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= wb_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Divisor is sampled into cur_div at each bit start so a
    // mid-frame change applies from the next bit boundary.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            tx_o     <= 1'b1;
            baud_cnt <= '0;
            cur_div  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state    <= S_START;
                        tx_o     <= 1'b0;
                        baud_cnt <= '0;
                        cur_div  <= divisor;
                        shreg    <= mem[rd_ptr];
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        bit_idx  <= '0;
                        tx_o     <= shreg[0];
                        baud_cnt <= '0;
                        cur_div  <= divisor;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        cur_div  <= divisor;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= nxt_idx;
                            tx_o    <= shreg[nxt_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        cur_div  <= divisor;
                        if (!empty) begin
                            state <= S_START;
                            tx_o  <= 1'b0;
                            shreg <= mem[rd_ptr];
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register vector table plus
// hand-written serial, FIFO, overflow and reset sequences.
module tb_wb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        ack;
    logic        tx;

    int checks = 0;
    int errors = 0;

    wb_uart_tx #(
        .FIFO_DEPTH(8),
        .RESET_DIV(16'd433)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_dat_o(dat_o),
        .wb_we_i(we),
        .wb_sel_i(sel),
        .wb_stb_i(stb),
        .wb_ack_o(ack),
        .tx_o(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     name, act, exp);
        end
    endtask

    task automatic xfer(input logic we_v,
                        input logic [1:0] adr_v,
                        input logic [31:0] dat_v,
                        input logic [3:0] sel_v,
                        output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        we    = we_v;
        adr   = adr_v;
        dat_i = dat_v;
        sel   = sel_v;
        stb   = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                rdata = dat_o;
                got   = 1'b1;
                break;
            end
        end
        stb = 1'b0;
        we  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack adr %0d", adr_v);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] dummy;
        xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        xfer(1'b0, a, 32'd0, 4'hF, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  frame;
        logic        saw_low;

        rst   = 1'b1;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 2'd0;
        dat_i = '0;
        sel   = 4'h0;
        #2;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vt[0] = '{1'b0, 2'd1, 32'h0, 4'hF, 1'b1, 32'h0000_0002};
        vt[1] = '{1'b0, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0000_01B1};
        vt[2] = '{1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 32'h0};
        vt[3] = '{1'b0, 2'd3, 32'h0, 4'hF, 1'b1, 32'h0};
        vt[4] = '{1'b1, 2'd2, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
        vt[5] = '{1'b0, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0000_5678};
        vt[6] = '{1'b1, 2'd2, 32'hFFFF_00CD, 4'h1, 1'b0, 32'h0};
        vt[7] = '{1'b0, 2'd2, 32'h0, 4'hF, 1'b1, 32'h0000_56CD};
        vt[8] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vt[9] = '{1'b0, 2'd3, 32'h0, 4'hF, 1'b1, 32'h0};

        for (int i = 0; i < 10; i++) begin
            xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, r);
            if (vt[i].chk)
                check($sformatf("vec%0d", i), r, vt[i].exp);
        end
        wr(2'd2, 32'h0000_01B1, 4'hF);

        // Single 0x55 frame at 4 cycles per bit.
        wr(2'd2, 32'd3, 4'hF);
        wr(2'd0, 32'h55, 4'h1);
        check("tx_idle_before", {31'd0, tx}, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("f55_c%0d", i), {31'd0, tx},
                  {31'd0, frame[i/4]});
        end
        @(posedge clk);
        #1;
        rd(2'd1, r);
        check("f55_status", r, 32'h0000_0002);

        // Nine bytes at 1 cycle per bit, no gaps expected.
        wr(2'd2, 32'd0, 4'hF);
        fork
            begin
                for (int b = 0; b < 9; b++)
                    wr(2'd0, 32'(b), 4'h1);
            end
            begin
                logic [9:0] cap;
                logic [9:0] exp10;
                logic       found;
                found = 1'b0;
                for (int w = 0; w < 30; w++) begin
                    if (tx == 1'b0) begin
                        found = 1'b1;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                check("b2b_start", {31'd0, found}, 32'd1);
                for (int f = 0; f < 9; f++) begin
                    for (int k = 0; k < 10; k++) begin
                        cap[k] = tx;
                        @(posedge clk);
                        #1;
                    end
                    exp10 = {1'b1, 8'(f), 1'b0};
                    check($sformatf("b2b_frame%0d", f),
                          {22'd0, cap}, {22'd0, exp10});
                end
            end
        join
        check("b2b_idle", {31'd0, tx}, 32'd1);
        rd(2'd1, r);
        check("b2b_status", r, 32'h0000_0002);

        // Overflow: first byte pops at once, 8 fill, 10th drops.
        wr(2'd2, 32'd100, 4'hF);
        for (int b = 0; b < 10; b++)
            wr(2'd0, 32'hA0 + 32'(b), 4'h1);
        rd(2'd1, r);
        check("ovf_full", r, 32'h0000_080D);
        wr(2'd1, 32'h8, 4'h2);
        rd(2'd1, r);
        check("ovf_noclr_sel", r, 32'h0000_080D);
        wr(2'd1, 32'h8, 4'h1);
        rd(2'd1, r);
        check("ovf_clr", r, 32'h0000_0805);
        do_reset();

        // Reset asserted in the middle of data bit 3.
        wr(2'd2, 32'd3, 4'hF);
        wr(2'd0, 32'h00, 4'h1);
        repeat (18) @(posedge clk);
        #1;
        check("mid_low", {31'd0, tx}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(2'd1, r);
        check("mid_status", r, 32'h0000_0002);
        saw_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (tx == 1'b0) saw_low = 1'b1;
        end
        check("mid_no_frame", {31'd0, saw_low}, 32'd0);

        // Held strobe: ack every other cycle.
        @(posedge clk);
        #1;
        we  = 1'b0;
        adr = 2'd2;
        sel = 4'hF;
        stb = 1'b1;
        check("cont_ack_pre", {31'd0, ack}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("cont_ack%0d", k), {31'd0, ack},
                  (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_dat%0d", k), dat_o,
                  (k % 2 == 0) ? 32'h0000_01B1 : 32'd0);
        end
        stb = 1'b0;
        wr(2'd2, 32'h0000_AB00, 4'h2);
        rd(2'd2, r);
        check("sel_hi_div", r, 32'h0000_ABB1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of two, 2..64).
REQ-002 The block SHALL have parameter RESET_DIV, default 16'd433, meaning the divisor reset value.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have the following ports:
- wb_clk_i  in  1  clock, rising edge.
- wb_rst_i  in  1  asynchronous active-high reset.
- wb_adr_i  in  2  word register select (byte address bits [3:2]).
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lane enables.
- wb_stb_i  in  1  strobe, already decoded by the interconnect.
- wb_ack_o  out  1  acknowledge.
- tx_o  out  1  serial output, idle high.

Function
REQ-005 The block SHALL use this register map:
- 0 TXDATA: write-only; reads return 0.
- 1 STATUS: read layout {count[7:0] at [15:8], overflow[3], busy[2], empty[1], full[0]}; all other bits read 0.
- 2 DIVISOR: read/write; bits [15:0].
- 3: reserved; reads 0, writes ignored.
REQ-006 wb_ack_o SHALL be registered and assert exactly one cycle after a cycle with wb_stb_i=1 and wb_ack_o=0. It SHALL deassert the following cycle, so back-to-back strobes give ack every other cycle.
REQ-007 Writes and their side effects SHALL take effect on the same edge that asserts wb_ack_o. wb_dat_o SHALL be valid while wb_ack_o=1 and 0 otherwise.
REQ-008 A TXDATA write with wb_sel_i[0]=1 SHALL push wb_dat_i[7:0] into the FIFO. A write with sel[0]=0 SHALL be acked with no push.
REQ-009 A TXDATA push while the FIFO is full SHALL be dropped and SHALL set sticky overflow. "Full" is evaluated before any same-cycle pop.
REQ-010 A STATUS write with wb_dat_i[3]=1 and sel[0]=1 SHALL clear overflow. If a dropped push and the clear occur together, overflow SHALL remain set.
REQ-011 DIVISOR writes SHALL honour byte lanes sel[0] for [7:0] and sel[1] for [15:8].
REQ-012 Each serial bit SHALL last exactly DIVISOR+1 clock cycles. Divisor 0 gives 1 cycle per bit.
REQ-013 A DIVISOR change mid-frame SHALL take effect from the next bit boundary.
REQ-014 The transmit FSM SHALL have states IDLE, START, DATA, STOP. Transitions:
- IDLE -> START when the FIFO is non-empty; pop in the same cycle; tx_o=0 from the next cycle.
- START -> DATA after one bit time.
- DATA shifts 8 bits LSB first using a 3-bit index; DATA -> STOP after bit 7.
- STOP drives tx_o=1 for one bit time, then goes to START (popping) if the FIFO is non-empty, else to IDLE.
REQ-015 A frame SHALL be 8N1, i.e. 10 bit times. Back-to-back frames SHALL have no idle gap.
REQ-016 busy SHALL be 1 in any state other than IDLE. empty SHALL be 1 when count==0; full SHALL be 1 when count==FIFO_DEPTH.
REQ-017 Simultaneous push and pop on a non-full FIFO SHALL leave count unchanged. FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 tx_o SHALL be registered, with no combinational path from any input.

Reset
REQ-019 On wb_rst_i=1 the block SHALL immediately apply, with no clock needed: tx_o=1, wb_ack_o=0, wb_dat_o=0, FSM=IDLE, FIFO empty (count=0, pointers 0), overflow=0, DIVISOR=RESET_DIV, bit counters 0.
REQ-020 Reset mid-frame SHALL abort the frame with tx_o=1 at once. The first frame after release SHALL start only on a new push.

Verification
REQ-021 The bench SHALL cover these scenarios:
- After reset: read STATUS -> 0x00000002; read DIVISOR -> 0x000001B1; tx_o=1.
- DIVISOR=3, write TXDATA 0x55 -> START 4 cycles low, bits 1,0,1,0,1,0,1,0 each 4 cycles, STOP 4 cycles high; busy returns to 0 after 40 cycles.
- DIVISOR=0, write 9 bytes 0x00..0x08 with FIFO_DEPTH=8 and the first pop before the 9th write -> all 9 frames sent back-to-back, no idle gap, overflow=0.
- DIVISOR=100, write 10 bytes fast -> STATUS full=1, count=8, overflow=1; STATUS write 0x8 -> overflow=0.
- Reset asserted during DATA bit 3 -> tx_o=1 asynchronously, STATUS=0x2 after release.
- Continuous wb_stb_i -> ack pattern 0,1,0,1; a sel=4'b0010 DIVISOR write of 0x0000AB00 changes only [15:8].
